gate_unit_arbiter: RTL and testbench

//   Shares one bitwise logic-gate unit (AND/OR/NAND/XOR/XNOR/NOT/NOR) among
//   N_REQ requesters. A round-robin arbiter grants one request at a time and

---
 rtl/gate_unit_arbiter_if.sv | 30 +++
 rtl/gate_unit_arbiter.sv | 154 +++++++++++++++
 tb/tb_gate_unit_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/gate_unit_arbiter_if.sv
// Request/result bundle between the client blocks and gate_unit_arbiter.
// Clients sit on the master modport; the arbiter sits on the slave modport.
interface gate_unit_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4
);
  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]       REQ;
  logic [3*N_REQ-1:0]     OP;
  logic [WIDTH*N_REQ-1:0] A;
  logic [WIDTH*N_REQ-1:0] B;
  logic [N_REQ-1:0]       GNT;
  logic [WIDTH-1:0]       RES;
  logic [IDW-1:0]         RES_ID;
  logic                   RES_VALID;
  logic                   RES_ACK;
  logic                   ERR;
  logic                   BUSY;

  modport master (
    output REQ, OP, A, B, RES_ACK,
    input  GNT, RES, RES_ID, RES_VALID, ERR, BUSY
  );

  modport slave (
    input  REQ, OP, A, B, RES_ACK,
    output GNT, RES, RES_ID, RES_VALID, ERR, BUSY
  );
endinterface

// File: rtl/gate_unit_arbiter.sv
// Round-robin arbiter sharing one registered bitwise gate unit among N_REQ clients.
// Each grant captures operands, computes the result next cycle, holds it until acked.
module gate_unit_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4
) (
  input logic              CLK,
  input logic              RST,
  gate_unit_arbiter_if.slave bus
);
  localparam int IDW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [IDW-1:0]   res_id_q, res_id_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  logic [2:0]       op_arr [N_REQ];
  logic [WIDTH-1:0] a_arr  [N_REQ];
  logic [WIDTH-1:0] b_arr  [N_REQ];

  logic             found;
  logic [IDW-1:0]   win_idx;
  logic [IDW-1:0]   cand;
  logic [IDW:0]     sum;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign op_arr[g] = bus.OP[3*g +: 3];
    assign a_arr[g]  = bus.A[WIDTH*g +: WIDTH];
    assign b_arr[g]  = bus.B[WIDTH*g +: WIDTH];
  end

  function automatic logic [WIDTH-1:0] gate_fn(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~(a & b);
      3'd3:    return a ^ b;
      3'd4:    return ~(a ^ b);
      3'd5:    return ~a;
      3'd6:    return ~(a | b);
      default: return '0;
    endcase
  endfunction

  // First set REQ bit found scanning upward from ptr, wrapping at N_REQ.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    sum     = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr_q} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(N_REQ)) sum = sum - (IDW+1)'(N_REQ);
      cand = sum[IDW-1:0];
      if (!found && bus.REQ[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = '0;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    id_d     = id_q;
    res_d    = res_q;
    res_id_d = res_id_q;
    valid_d  = valid_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d[win_idx] = 1'b1;
          op_d    = op_arr[win_idx];
          a_d     = a_arr[win_idx];
          b_d     = b_arr[win_idx];
          id_d    = win_idx;
          ptr_d   = (win_idx == IDW'(N_REQ-1)) ? '0 : win_idx + IDW'(1);
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d    = gate_fn(op_q, a_q, b_q);
        res_id_d = id_q;
        valid_d  = 1'b1;
        err_d    = (op_q == 3'd7);
        state_d  = RESP;
      end
      RESP: begin
        if (bus.RES_ACK) begin
          valid_d = 1'b0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= '0;
      res_q    <= '0;
      res_id_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      id_q     <= id_d;
      res_q    <= res_d;
      res_id_q <= res_id_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign bus.GNT       = gnt_q;
  assign bus.RES       = res_q;
  assign bus.RES_ID    = res_id_q;
  assign bus.RES_VALID = valid_q;
  assign bus.ERR       = err_q;
  assign bus.BUSY      = (state_q != IDLE);
endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Directed bench for gate_unit_arbiter with N_REQ=4, WIDTH=4.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_gate_unit_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  gate_unit_arbiter_if #(.N_REQ(4), .WIDTH(4)) bus ();

  gate_unit_arbiter #(.N_REQ(4), .WIDTH(4)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int unsigned r, input logic [2:0] op,
                        input logic [3:0] a, input logic [3:0] b);
    bus.OP[3*r +: 3] = op;
    bus.A[4*r +: 4]  = a;
    bus.B[4*r +: 4]  = b;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.REQ = '0;
    bus.RES_ACK = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++; if (bus.GNT !== 4'b0000) begin failures++; $display("FAIL reset_gnt: got %b expected 0000", bus.GNT); end
    checks++; if (bus.RES !== 4'b0000) begin failures++; $display("FAIL reset_res: got %b expected 0000", bus.RES); end
    checks++; if (bus.RES_ID !== 2'd0) begin failures++; $display("FAIL reset_res_id: got %0d expected 0", bus.RES_ID); end
    checks++; if (bus.RES_VALID !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", bus.RES_VALID); end
    checks++; if (bus.ERR !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", bus.ERR); end
    checks++; if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.BUSY); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL idle_no_req_busy: got %b expected 0", bus.BUSY); end
  endtask

  task automatic test_basic();
    set_op(0, 3'd0, 4'b1100, 4'b1010);
    bus.REQ = 4'b0001;
    tick();
    checks++; if (bus.GNT !== 4'b0001) begin failures++; $display("FAIL basic_gnt: got %b expected 0001", bus.GNT); end
    checks++; if (bus.BUSY !== 1'b1) begin failures++; $display("FAIL basic_busy: got %b expected 1", bus.BUSY); end
    checks++; if (bus.RES_VALID !== 1'b0) begin failures++; $display("FAIL basic_valid_early: got %b expected 0", bus.RES_VALID); end
    bus.REQ = 4'b0000;
    tick();
    checks++; if (bus.GNT !== 4'b0000) begin failures++; $display("FAIL basic_gnt_pulse: got %b expected 0000", bus.GNT); end
    checks++; if (bus.RES_VALID !== 1'b1) begin failures++; $display("FAIL basic_valid: got %b expected 1", bus.RES_VALID); end
    checks++; if (bus.RES !== 4'b1000) begin failures++; $display("FAIL basic_res: got %b expected 1000", bus.RES); end
    checks++; if (bus.RES_ID !== 2'd0) begin failures++; $display("FAIL basic_res_id: got %0d expected 0", bus.RES_ID); end
    checks++; if (bus.ERR !== 1'b0) begin failures++; $display("FAIL basic_err: got %b expected 0", bus.ERR); end
    bus.RES_ACK = 1'b1;
    tick();
    bus.RES_ACK = 1'b0;
    checks++; if (bus.RES_VALID !== 1'b0) begin failures++; $display("FAIL basic_ack_valid: got %b expected 0", bus.RES_VALID); end
    checks++; if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL basic_ack_busy: got %b expected 0", bus.BUSY); end
    checks++; if (bus.RES !== 4'b1000) begin failures++; $display("FAIL basic_res_kept: got %b expected 1000", bus.RES); end
  endtask

  task automatic test_opcodes();
    logic [3:0] exp_res [8];
    exp_res = '{4'b1000, 4'b1110, 4'b0111, 4'b0110, 4'b1001, 4'b0011, 4'b0001, 4'b0000};
    for (int unsigned op = 0; op < 8; op++) begin
      set_op(0, 3'(op), 4'b1100, 4'b1010);
      bus.REQ = 4'b0001;
      tick();
      checks++; if (bus.GNT !== 4'b0001) begin failures++; $display("FAIL op%0d_gnt: got %b expected 0001", op, bus.GNT); end
      bus.REQ = 4'b0000;
      tick();
      checks++; if (bus.RES !== exp_res[op]) begin failures++; $display("FAIL op%0d_res: got %b expected %b", op, bus.RES, exp_res[op]); end
      checks++; if (bus.ERR !== (op == 7)) begin failures++; $display("FAIL op%0d_err: got %b expected %b", op, bus.ERR, (op == 7)); end
      bus.RES_ACK = 1'b1;
      tick();
      bus.RES_ACK = 1'b0;
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_gnt;
    apply_reset();
    for (int unsigned r = 0; r < 4; r++) set_op(r, 3'd1, 4'(r), 4'b0000);
    bus.REQ = 4'b1111;
    bus.RES_ACK = 1'b1;
    for (int unsigned c = 0; c < 13; c++) begin
      tick();
      exp_gnt = (c % 3 == 0) ? 4'(1 << ((c / 3) % 4)) : 4'b0000;
      checks++; if (bus.GNT !== exp_gnt) begin failures++; $display("FAIL rr_gnt_c%0d: got %b expected %b", c, bus.GNT, exp_gnt); end
    end
    bus.REQ = 4'b0000;
    tick();
    tick();
    bus.RES_ACK = 1'b0;
    checks++; if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL rr_end_busy: got %b expected 0", bus.BUSY); end
  endtask

  task automatic test_hold();
    set_op(3, 3'd1, 4'b0101, 4'b0010);
    set_op(1, 3'd2, 4'b1111, 4'b0011);
    set_op(2, 3'd3, 4'b1111, 4'b1111);
    bus.REQ = 4'b1000;
    tick();
    checks++; if (bus.GNT !== 4'b1000) begin failures++; $display("FAIL hold_first_gnt: got %b expected 1000", bus.GNT); end
    bus.REQ = 4'b0110;
    tick();
    for (int unsigned c = 0; c < 5; c++) begin
      checks++; if (bus.GNT !== 4'b0000) begin failures++; $display("FAIL hold_gnt_c%0d: got %b expected 0000", c, bus.GNT); end
      checks++; if (bus.BUSY !== 1'b1) begin failures++; $display("FAIL hold_busy_c%0d: got %b expected 1", c, bus.BUSY); end
      checks++; if (bus.RES_VALID !== 1'b1) begin failures++; $display("FAIL hold_valid_c%0d: got %b expected 1", c, bus.RES_VALID); end
      checks++; if (bus.RES !== 4'b0111) begin failures++; $display("FAIL hold_res_c%0d: got %b expected 0111", c, bus.RES); end
      checks++; if (bus.RES_ID !== 2'd3) begin failures++; $display("FAIL hold_res_id_c%0d: got %0d expected 3", c, bus.RES_ID); end
      tick();
    end
    bus.RES_ACK = 1'b1;
    tick();
    bus.RES_ACK = 1'b0;
    checks++; if (bus.RES_VALID !== 1'b0) begin failures++; $display("FAIL hold_ack_valid: got %b expected 0", bus.RES_VALID); end
    checks++; if (bus.GNT !== 4'b0000) begin failures++; $display("FAIL hold_ack_gnt: got %b expected 0000", bus.GNT); end
    tick();
    checks++; if (bus.GNT !== 4'b0010) begin failures++; $display("FAIL hold_next_gnt: got %b expected 0010", bus.GNT); end
    bus.REQ = 4'b0000;
    tick();
    checks++; if (bus.RES !== 4'b1100) begin failures++; $display("FAIL hold_next_res: got %b expected 1100", bus.RES); end
    checks++; if (bus.RES_ID !== 2'd1) begin failures++; $display("FAIL hold_next_res_id: got %0d expected 1", bus.RES_ID); end
    bus.RES_ACK = 1'b1;
    tick();
    bus.RES_ACK = 1'b0;
  endtask

  task automatic test_reset_exec();
    set_op(3, 3'd0, 4'b1111, 4'b1111);
    set_op(0, 3'd0, 4'b1111, 4'b1111);
    bus.REQ = 4'b1000;
    tick();
    checks++; if (bus.GNT !== 4'b1000) begin failures++; $display("FAIL rx_gnt: got %b expected 1000", bus.GNT); end
    bus.REQ = 4'b0000;
    rst = 1'b1;
    #1;
    checks++; if (bus.GNT !== 4'b0000) begin failures++; $display("FAIL rx_async_gnt: got %b expected 0000", bus.GNT); end
    checks++; if (bus.RES !== 4'b0000) begin failures++; $display("FAIL rx_async_res: got %b expected 0000", bus.RES); end
    checks++; if (bus.RES_ID !== 2'd0) begin failures++; $display("FAIL rx_async_res_id: got %0d expected 0", bus.RES_ID); end
    checks++; if (bus.RES_VALID !== 1'b0) begin failures++; $display("FAIL rx_async_valid: got %b expected 0", bus.RES_VALID); end
    checks++; if (bus.ERR !== 1'b0) begin failures++; $display("FAIL rx_async_err: got %b expected 0", bus.ERR); end
    checks++; if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL rx_async_busy: got %b expected 0", bus.BUSY); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (bus.RES_VALID !== 1'b0) begin failures++; $display("FAIL rx_discarded_valid: got %b expected 0", bus.RES_VALID); end
    bus.REQ = 4'b0101;
    bus.RES_ACK = 1'b1;
    tick();
    checks++; if (bus.GNT !== 4'b0001) begin failures++; $display("FAIL rx_first_gnt: got %b expected 0001", bus.GNT); end
    tick();
    tick();
    tick();
    checks++; if (bus.GNT !== 4'b0100) begin failures++; $display("FAIL rx_second_gnt: got %b expected 0100", bus.GNT); end
    bus.REQ = 4'b0000;
    tick();
    tick();
    bus.RES_ACK = 1'b0;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b0;
    bus.REQ     = '0;
    bus.OP      = '0;
    bus.A       = '0;
    bus.B       = '0;
    bus.RES_ACK = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_opcodes();
    test_round_robin();
    test_hold();
    test_reset_exec();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
